calc_multi_op: RTL and testbench
================================

// Module: calc_multi_op
// PURPOSE
//  Parametrised keypad calculator core, successor to the single-op calc FSM.
//  Accepts 4-bit key codes over a valid/ready handshake and accumulates decimal operands.
//  Executes add, sub, mul or div on unsigned operands. Mul and div are sequential.
//  Converts the operand being entered, or the result, to BCD and scans it out one digit per clock.
//  Sits between the keypad debouncer and the 7-segment display multiplexer.
// PARAMETERS
//  N_DIGITS  8    display digits; operands/results limited to 0..10^N_DIGITS-1
//  W         27   datapath width; must satisfy 2^W >= 10^N_DIGITS
//  BLANK_LZ  1    1: leading zeros (pos>0) shown as 4'hF (blank); 0: shown as 0
// PORTS
//  clock      in   1              rising-edge clock
//  reset      in   1              asynchronous, active-high
//  cmd        in   4              key code: 0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals, 15 backspace
//  cmd_valid  in   1              cmd present this cycle
//  cmd_ready  out  1              core can accept cmd; transfer when cmd_valid & cmd_ready
//  status     out  2              00 error, 01 busy, 10 ready
//  err_code   out  2              00 none, 01 overflow, 10 div-by-zero, 11 negative result / bad sequence
//  data       out  4              BCD digit for position pos (4'hE in ERROR, 4'hF when blanked)
//  pos        out  $clog2(N_DIGITS)  digit position currently on data; 0 = least significant
//  state      out  3              current FSM state (debug)
// BEHAVIOUR
//  Reset values:
//   - state=ENTRY_A, acc=regA=regB=0, op=add, status=01, cmd_ready=0, err_code=00, data=0, pos=0.
//   - Immediately after reset, one CONV of acc=0 runs. status=10 and cmd_ready=1 after W cycles.
//  States: ENTRY_A, ENTRY_B, EXEC, CONV, ERROR.
//   - cmd_ready=1 only in ENTRY_A/ENTRY_B with CONV finished.
//   - status=10 when cmd_ready=1, 00 in ERROR, 01 otherwise.
//  Digit d:
//   - acc <= acc*10+d if the result is <= 10^N_DIGITS-1; otherwise the digit is dropped and acc is unchanged.
//   - In both cases the core goes through CONV.
//  Backspace: acc <= acc/10 (constant divide, combinational allowed), then CONV.
//  Op key in ENTRY_A: regA <= acc; acc <= 0; op <= key; go to ENTRY_B, then CONV.
//  Op key in ENTRY_B:
//   - No digit entered since the op: op is replaced, no error.
//   - Otherwise: ERROR, err=11.
//  Equals:
//   - In ENTRY_A: ignored, but accepted (one-cycle handshake, no CONV).
//   - In ENTRY_B: regB <= acc, then EXEC.
//  EXEC:
//   - add/sub: 1 cycle. sub with regB > regA: ERROR, err=11. add result > 10^N_DIGITS-1: ERROR, err=01.
//   - mul: shift-add over W cycles; product > 10^N_DIGITS-1 (2W-bit compare): ERROR, err=01.
//   - div: restoring division over W cycles; quotient kept, remainder dropped; regB==0 detected in cycle 1: ERROR, err=10.
//   - On success: acc <= result, state ENTRY_A, then CONV. The result can be the first operand of a chained op.
//  CONV: sequential double-dabble of acc into N_DIGITS BCD registers, exactly W cycles. BCD registers update atomically at the end.
//  Latency, accepting edge to cmd_ready re-high:
//   - digit/backspace/op: W+1 cycles.
//   - equals with add/sub: W+2 cycles.
//   - equals with mul/div: 2W+1 cycles.
//  Display scan:
//   - pos free-runs 0..N_DIGITS-1 and wraps to 0, one step per clock, in every state.
//   - data = bcd[pos], registered, same cycle as pos.
//   - Blanking per BLANK_LZ: a digit is blanked when it and all higher digits are 0 and pos != 0.
//   - ERROR: data = 4'hE at every pos.
//  ERROR is sticky until reset; cmd_ready=0.
//  cmd_valid while cmd_ready=0: no transfer, no effect.
//  reset asserted mid-EXEC or mid-CONV aborts immediately and takes the reset values.
// STRUCTURE
//  calc_pkg:
//   - state_t enum.
//   - CMD_ADD/SUB/MUL/DIV/EQ/BSP constants.
//   - STATUS_ERR/BUSY/READY constants.
//   - ERR_* codes.
//  Sub-module calc_bin2bcd:
//   - Parameters W, N_DIGITS.
//   - Ports: start/busy/done, bin in, bcd out.
//   - Instanced once; also used for the post-reset CONV.
//  Mul/div sequencer lives in calc_multi_op; it shares one W-cycle counter with nothing else.
// TESTING
//  Default parameters; check display by sampling data over one full pos sweep.
//  1. Keys 1,2,+,3,4,= -> acc=46; display 46 with 6 leading blanks; status=10; err=00.
//  2. Keys 7,-,9,= -> status=00, err_code=11, data=4'hE at all 8 positions; reset -> status=10 after W cycles, display 0.
//  3. Keys 1,2,3,4,*,5,6,7,8,= -> 7006652 after exactly 2W+1 cycles from equals. Then +,1,= -> 7006653 (chained).
//  4. Keys 1,0,0,/,7,= -> 14. Keys 1,0,0,/,0,= -> err_code=10.
//  5. Enter 9 nine times -> acc=99999999 (ninth digit dropped); backspace -> 9999999.
//     Then *,9,9,= -> err_code=01.
//  6. cmd_valid held high while cmd_ready=0 -> exactly one key consumed.
//     +,- before any digit -> op=sub, no error. reset pulse mid-mul -> reset values, pos=0.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared types and constants for the multi-operation keypad
//                calculator core: FSM state encoding, key codes, status and
//                error codes, plus small key-classification helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Controller states; the encoding is visible on the debug 'state' port.
    typedef enum logic [2:0] {
        ST_ENTRY_A = 3'd0,
        ST_ENTRY_B = 3'd1,
        ST_EXEC    = 3'd2,
        ST_CONV    = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    // Key codes; 0..9 are decimal digits.
    localparam logic [3:0] CMD_ADD = 4'd10;
    localparam logic [3:0] CMD_SUB = 4'd11;
    localparam logic [3:0] CMD_MUL = 4'd12;
    localparam logic [3:0] CMD_DIV = 4'd13;
    localparam logic [3:0] CMD_EQ  = 4'd14;
    localparam logic [3:0] CMD_BSP = 4'd15;

    // Status port encoding.
    localparam logic [1:0] STATUS_ERR   = 2'b00;
    localparam logic [1:0] STATUS_BUSY  = 2'b01;
    localparam logic [1:0] STATUS_READY = 2'b10;

    // Error code encoding.
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_DIVZ = 2'b10;
    localparam logic [1:0] ERR_NEG  = 2'b11;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] key);
        return (key >= CMD_ADD) && (key <= CMD_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_bin2bcd.sv
`default_nettype none
// ============================================================================
//  Module      : calc_bin2bcd
//  Description : Sequential double-dabble binary-to-BCD converter. One shift
//                step per clock, exactly W steps per conversion. The BCD output
//                registers change only once, at the end of a conversion.
//  Ports       : clock  - rising-edge clock
//                reset  - asynchronous, active-high
//                start  - load 'bin' and begin a conversion (ignored if busy)
//                bin    - binary value to convert
//                busy   - conversion in progress
//                done   - one-cycle pulse after the final step
//                bcd    - N_DIGITS packed BCD digits, digit 0 in bits [3:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_bin2bcd
    import calc_pkg::*;
#(
    parameter int W        = 27,
    parameter int N_DIGITS = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [W-1:0]            bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*N_DIGITS-1:0]   bcd
);

    localparam int c_cnt_w = $clog2(W + 1);
    localparam int c_bcd_w = 4 * N_DIGITS;

    logic [W-1:0]          r_shift;
    logic [c_bcd_w-1:0]    r_work;
    logic [c_bcd_w-1:0]    r_bcd;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic [c_bcd_w-1:0]    w_adj;
    logic [c_bcd_w+W-1:0]  w_step;

    // Add-3 correction on every digit that is 5 or more before the shift.
    generate
        for (genvar i = 0; i < N_DIGITS; i++) begin : g_dabble
            assign w_adj[4*i +: 4] = (r_work[4*i +: 4] >= 4'd5) ?
                                     (r_work[4*i +: 4] + 4'd3) : r_work[4*i +: 4];
        end
    endgenerate

    // BCD digits and remaining binary bits shift as one register; the bit
    // falling off the top only matters for values outside the display range.
    assign w_step = {w_adj, r_shift} << 1;

    // Reset leaves the converter mid-run on a zero input so that the
    // power-up conversion of acc=0 starts without a start pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_work  <= '0;
            r_bcd   <= '0;
            r_cnt   <= c_cnt_w'(W);
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start && !r_busy) begin
                r_shift <= bin;
                r_work  <= '0;
                r_cnt   <= c_cnt_w'(W);
                r_busy  <= 1'b1;
            end else if (r_busy) begin
                r_work  <= w_step[c_bcd_w+W-1:W];
                r_shift <= w_step[W-1:0];
                r_cnt   <= r_cnt - c_cnt_w'(1);
                if (r_cnt == c_cnt_w'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_bcd  <= w_step[c_bcd_w+W-1:W];
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/calc_multi_op.sv
`default_nettype none
// ============================================================================
//  Module      : calc_multi_op
//  Description : Keypad calculator core. Accumulates decimal operands from key
//                codes, executes add/sub (single cycle) or mul/div (W-cycle
//                shift-add / restoring division), converts the current value
//                to BCD and scans it out one digit per clock.
//  Ports       : clock     - rising-edge clock
//                reset     - asynchronous, active-high
//                cmd       - key code (0-9 digit, 10 + 11 - 12 * 13 / 14 = 15 bsp)
//                cmd_valid - key present
//                cmd_ready - key accepted when cmd_valid & cmd_ready
//                status    - 00 error, 01 busy, 10 ready
//                err_code  - 00 none, 01 overflow, 10 div-by-zero, 11 neg/sequence
//                data      - BCD digit at 'pos' (E in error, F when blanked)
//                pos       - scanned digit position, 0 = least significant
//                state     - controller state (debug)
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_multi_op
    import calc_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int W        = 27,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [3:0]                  cmd,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    output logic [1:0]                  status,
    output logic [1:0]                  err_code,
    output logic [3:0]                  data,
    output logic [$clog2(N_DIGITS)-1:0] pos,
    output logic [2:0]                  state
);

    localparam int             c_pos_w   = $clog2(N_DIGITS);
    localparam int             c_cnt_w   = $clog2(W + 1);
    localparam logic [W-1:0]   c_max_val = W'(10**N_DIGITS - 1);

    // Controller registers and their next values
    state_t             r_state, w_state_next;
    state_t             r_ret,   w_ret_next;
    logic [W-1:0]       r_acc,   w_acc_next;
    logic [W-1:0]       r_rega,  w_rega_next;
    logic [W-1:0]       r_regb,  w_regb_next;
    logic [3:0]         r_op,    w_op_next;
    logic               r_seen,  w_seen_next;
    logic [1:0]         r_err,   w_err_next;

    // Mul/div sequencer
    logic [2*W-1:0]     r_p;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_exec_load;
    logic               w_exec_step;

    // Converter interface
    logic                   w_conv_start;
    logic                   w_conv_busy;
    logic                   w_conv_done;
    logic [4*N_DIGITS-1:0]  w_bcd;

    // Display scan
    logic [c_pos_w-1:0] r_pos, w_pos_next;
    logic [3:0]         r_data, w_data_next;
    logic [N_DIGITS-1:0] w_hi_nz;

    // Arithmetic
    logic               w_xfer;
    logic [W+3:0]       w_acc_dig;
    logic               w_dig_ok;
    logic [W:0]         w_add;
    logic [W:0]         w_mul_sum;
    logic [2*W-1:0]     w_mul_next;
    logic [W:0]         w_div_rsh;
    logic               w_div_ge;
    logic [W-1:0]       w_div_rem;
    logic [2*W-1:0]     w_div_next;

    assign cmd_ready = ((r_state == ST_ENTRY_A) || (r_state == ST_ENTRY_B)) && !w_conv_busy;
    assign w_xfer    = cmd_valid && cmd_ready;

    // Digit append, kept only while it stays inside the display range.
    assign w_acc_dig = (W+4)'(r_acc) * (W+4)'(10) + (W+4)'(cmd);
    assign w_dig_ok  = w_acc_dig <= (W+4)'(c_max_val);

    assign w_add = {1'b0, r_rega} + {1'b0, r_regb};

    // Shift-add multiply: low half starts as the multiplier and drains out
    // the bottom while the partial product grows into the top half.
    assign w_mul_sum  = {1'b0, r_p[2*W-1:W]} + (r_p[0] ? {1'b0, r_rega} : {(W+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_p[W-1:1]};

    // Restoring divide: top half is the partial remainder, low half starts as
    // the dividend and fills with quotient bits from the right.
    assign w_div_rsh  = {r_p[2*W-1:W], r_p[W-1]};
    assign w_div_ge   = w_div_rsh >= {1'b0, r_regb};
    assign w_div_rem  = w_div_ge ? (w_div_rsh[W-1:0] - r_regb) : w_div_rsh[W-1:0];
    assign w_div_next = {w_div_rem, r_p[W-2:0], w_div_ge};

    always_comb begin
        w_state_next = r_state;
        w_ret_next   = r_ret;
        w_acc_next   = r_acc;
        w_rega_next  = r_rega;
        w_regb_next  = r_regb;
        w_op_next    = r_op;
        w_seen_next  = r_seen;
        w_err_next   = r_err;
        w_exec_load  = 1'b0;
        w_exec_step  = 1'b0;
        w_conv_start = 1'b0;

        case (r_state)
            ST_ENTRY_A, ST_ENTRY_B: begin
                if (w_xfer) begin
                    if (is_digit(cmd)) begin
                        if (w_dig_ok) begin
                            w_acc_next = w_acc_dig[W-1:0];
                        end
                        w_seen_next  = 1'b1;
                        w_ret_next   = r_state;
                        w_conv_start = 1'b1;
                        w_state_next = ST_CONV;
                    end else if (cmd == CMD_BSP) begin
                        w_acc_next   = r_acc / W'(10);
                        w_ret_next   = r_state;
                        w_conv_start = 1'b1;
                        w_state_next = ST_CONV;
                    end else if (is_op(cmd)) begin
                        if (r_state == ST_ENTRY_A) begin
                            w_rega_next  = r_acc;
                            w_acc_next   = '0;
                            w_op_next    = cmd;
                            w_seen_next  = 1'b0;
                            w_ret_next   = ST_ENTRY_B;
                            w_conv_start = 1'b1;
                            w_state_next = ST_CONV;
                        end else if (!r_seen) begin
                            // Operator pressed twice in a row: last one wins.
                            w_op_next    = cmd;
                            w_ret_next   = ST_ENTRY_B;
                            w_conv_start = 1'b1;
                            w_state_next = ST_CONV;
                        end else begin
                            w_err_next   = ERR_NEG;
                            w_state_next = ST_ERROR;
                        end
                    end else if (r_state == ST_ENTRY_B) begin
                        // Equals with a pending operation; in ENTRY_A it is a no-op.
                        w_regb_next  = r_acc;
                        w_exec_load  = 1'b1;
                        w_state_next = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                case (r_op)
                    CMD_SUB: begin
                        if (r_regb > r_rega) begin
                            w_err_next   = ERR_NEG;
                            w_state_next = ST_ERROR;
                        end else begin
                            w_acc_next   = r_rega - r_regb;
                            w_conv_start = 1'b1;
                            w_ret_next   = ST_ENTRY_A;
                            w_state_next = ST_CONV;
                        end
                    end
                    CMD_MUL: begin
                        w_exec_step = 1'b1;
                        if (r_cnt == c_cnt_w'(1)) begin
                            if (w_mul_next > {{W{1'b0}}, c_max_val}) begin
                                w_err_next   = ERR_OVF;
                                w_state_next = ST_ERROR;
                            end else begin
                                w_acc_next   = w_mul_next[W-1:0];
                                w_conv_start = 1'b1;
                                w_ret_next   = ST_ENTRY_A;
                                w_state_next = ST_CONV;
                            end
                        end
                    end
                    CMD_DIV: begin
                        if ((r_cnt == c_cnt_w'(W)) && (r_regb == '0)) begin
                            w_err_next   = ERR_DIVZ;
                            w_state_next = ST_ERROR;
                        end else begin
                            w_exec_step = 1'b1;
                            if (r_cnt == c_cnt_w'(1)) begin
                                w_acc_next   = w_div_next[W-1:0];
                                w_conv_start = 1'b1;
                                w_ret_next   = ST_ENTRY_A;
                                w_state_next = ST_CONV;
                            end
                        end
                    end
                    default: begin
                        if (w_add > {1'b0, c_max_val}) begin
                            w_err_next   = ERR_OVF;
                            w_state_next = ST_ERROR;
                        end else begin
                            w_acc_next   = w_add[W-1:0];
                            w_conv_start = 1'b1;
                            w_ret_next   = ST_ENTRY_A;
                            w_state_next = ST_CONV;
                        end
                    end
                endcase
            end

            ST_CONV: begin
                if (w_conv_done) begin
                    w_state_next = r_ret;
                end
            end

            default: begin
                // ST_ERROR holds until reset.
                w_state_next = ST_ERROR;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_ENTRY_A;
            r_ret   <= ST_ENTRY_A;
            r_acc   <= '0;
            r_rega  <= '0;
            r_regb  <= '0;
            r_op    <= CMD_ADD;
            r_seen  <= 1'b0;
            r_err   <= ERR_NONE;
        end else begin
            r_state <= w_state_next;
            r_ret   <= w_ret_next;
            r_acc   <= w_acc_next;
            r_rega  <= w_rega_next;
            r_regb  <= w_regb_next;
            r_op    <= w_op_next;
            r_seen  <= w_seen_next;
            r_err   <= w_err_next;
        end
    end

    // Mul/div sequencer; the multiplier is the value being latched into regB.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_p   <= '0;
            r_cnt <= '0;
        end else if (w_exec_load) begin
            r_p   <= (r_op == CMD_MUL) ? {{W{1'b0}}, r_acc} : {{W{1'b0}}, r_rega};
            r_cnt <= c_cnt_w'(W);
        end else if (w_exec_step) begin
            r_p   <= (r_op == CMD_MUL) ? w_mul_next : w_div_next;
            r_cnt <= r_cnt - c_cnt_w'(1);
        end
    end

    calc_bin2bcd #(
        .W        (W),
        .N_DIGITS (N_DIGITS)
    ) u_bin2bcd (
        .clock (clock),
        .reset (reset),
        .start (w_conv_start),
        .bin   (w_acc_next),
        .busy  (w_conv_busy),
        .done  (w_conv_done),
        .bcd   (w_bcd)
    );

    // w_hi_nz[k]: some digit at position k or above is non-zero.
    generate
        for (genvar k = 0; k < N_DIGITS; k++) begin : g_hi_nz
            assign w_hi_nz[k] = |w_bcd[4*N_DIGITS-1:4*k];
        end
    endgenerate

    assign w_pos_next = (r_pos == c_pos_w'(N_DIGITS - 1)) ? '0 : (r_pos + c_pos_w'(1));

    // data is registered together with pos so the pair always matches.
    always_comb begin
        w_data_next = w_bcd[4*w_pos_next +: 4];
        if (w_state_next == ST_ERROR) begin
            w_data_next = 4'hE;
        end else if (BLANK_LZ && (w_pos_next != '0) && !w_hi_nz[w_pos_next]) begin
            w_data_next = 4'hF;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pos  <= '0;
            r_data <= '0;
        end else begin
            r_pos  <= w_pos_next;
            r_data <= w_data_next;
        end
    end

    always_comb begin
        status = STATUS_BUSY;
        if (r_state == ST_ERROR) begin
            status = STATUS_ERR;
        end else if (cmd_ready) begin
            status = STATUS_READY;
        end
    end

    assign err_code = r_err;
    assign data     = r_data;
    assign pos      = r_pos;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_calc_multi_op.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_calc_multi_op
//  Description : Self-checking bench for calc_multi_op: table of key strings
//                with expected value/status/error/latency, plus hand-written
//                sequences for reset, handshake and mid-operation reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_multi_op;

    localparam int W = 27;
    localparam int N = 8;
    localparam int NV = 16;
    localparam int BOUND = 400;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cmd = 4'd0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] status;
    logic [1:0] err_code;
    logic [3:0] data;
    logic [2:0] pos;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    calc_multi_op dut (
        .clock     (clock),
        .reset     (reset),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .status    (status),
        .err_code  (err_code),
        .data      (data),
        .pos       (pos),
        .state     (state)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        string      keys;
        int         val;     // -1: error display expected
        logic [1:0] st;
        logic [1:0] err;
        int         lat;     // latency of last key, 0: not checked
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] code_of(input byte c);
        int ci;
        ci = int'(c);
        case (c)
            "+":     return 4'd10;
            "-":     return 4'd11;
            "*":     return 4'd12;
            "/":     return 4'd13;
            "=":     return 4'd14;
            "b":     return 4'd15;
            default: return 4'(ci - 48);
        endcase
    endfunction

    function automatic logic [3:0] exp_digit(input int v, input int p);
        int pw;
        pw = 1;
        for (int i = 0; i < p; i++) pw = pw * 10;
        if (p != 0 && v < pw) return 4'hF;
        return 4'((v / pw) % 10);
    endfunction

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!cmd_ready && status != 2'b00 && n < BOUND) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= BOUND) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: cmd_ready=%0d required 1", name, cmd_ready);
        end
    endtask

    // Sends one key; lat = clock edges from the accepting edge until ready
    // (or error) is observed.
    task automatic press(input logic [3:0] k, output int lat);
        lat = -1;
        wait_ready("key_wait");
        if (status == 2'b00) return;
        cmd = k;
        cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (!cmd_ready && status != 2'b00 && lat < BOUND);
        if (lat >= BOUND) begin
            checks++;
            failures++;
            $display("FAIL key_timeout: cmd_ready=%0d required 1", cmd_ready);
        end
    endtask

    task automatic press_str(input string s, output int lat);
        lat = 0;
        for (int j = 0; j < s.len(); j++) press(code_of(s[j]), lat);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        wait_ready("boot");
    endtask

    task automatic check_display(input string name, input int v, input bit is_err);
        int bad;
        int bad_pos;
        logic [3:0] exp;
        logic [3:0] bad_got;
        logic [3:0] bad_exp;
        logic [2:0] prev;
        bad = 0; bad_pos = 0; bad_got = 4'd0; bad_exp = 4'd0;
        prev = pos;
        for (int i = 0; i < N; i++) begin
            @(posedge clock); #1;
            exp = is_err ? 4'hE : exp_digit(v, int'(pos));
            if (data != exp || pos != prev + 3'd1) begin
                if (bad == 0) begin
                    bad_pos = int'(pos); bad_got = data; bad_exp = exp;
                end
                bad++;
            end
            prev = pos;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s_display: pos %0d data %h expected %h (%0d bad samples)",
                     name, bad_pos, bad_got, bad_exp, bad);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;

        vecs[0]  = '{"add",        "12+34=",          46,       2'b10, 2'b00, W+2};
        vecs[1]  = '{"sub_neg",    "7-9=",            -1,       2'b00, 2'b11, 0};
        vecs[2]  = '{"mul",        "1234*5678=",      7006652,  2'b10, 2'b00, 2*W+1};
        vecs[3]  = '{"div",        "100/7=",          14,       2'b10, 2'b00, 2*W+1};
        vecs[4]  = '{"div_zero",   "100/0=",          -1,       2'b00, 2'b10, 0};
        vecs[5]  = '{"digit_drop", "999999999",       99999999, 2'b10, 2'b00, W+1};
        vecs[6]  = '{"backspace",  "999999999b",      9999999,  2'b10, 2'b00, W+1};
        vecs[7]  = '{"mul_ovf",    "999999999b*99=",  -1,       2'b00, 2'b01, 0};
        vecs[8]  = '{"add_ovf",    "99999999+1=",     -1,       2'b00, 2'b01, 0};
        vecs[9]  = '{"sub_zero",   "5-5=",            0,        2'b10, 2'b00, W+2};
        vecs[10] = '{"op_replace", "8+-3=",           5,        2'b10, 2'b00, W+2};
        vecs[11] = '{"bad_seq",    "8+3+",            -1,       2'b00, 2'b11, 0};
        vecs[12] = '{"eq_idle",    "=5",              5,        2'b10, 2'b00, W+1};
        vecs[13] = '{"add_max",    "99999998+1=",     99999999, 2'b10, 2'b00, W+2};
        vecs[14] = '{"mul_zero",   "12*0=",           0,        2'b10, 2'b00, 2*W+1};
        vecs[15] = '{"mul_max",    "99999999*1=",     99999999, 2'b10, 2'b00, 2*W+1};

        // Reset values while reset is held, then power-up conversion length.
        repeat (2) @(posedge clock); #1;
        check("rst_state", int'(state), 0);
        check("rst_status", int'(status), 1);
        check("rst_ready", int'(cmd_ready), 0);
        check("rst_err", int'(err_code), 0);
        check("rst_data", int'(data), 0);
        check("rst_pos", int'(pos), 0);
        reset = 1'b0;
        n = 0;
        while (!cmd_ready && n < BOUND) begin
            @(posedge clock); #1;
            n++;
        end
        check("boot_latency", n, W);
        check("boot_status", int'(status), 2);
        check_display("boot", 0, 1'b0);

        // Equals with nothing pending: one-cycle handshake, no conversion.
        press(4'd14, lat);
        check("eq_idle_lat", lat, 1);
        check("eq_idle_state", int'(state), 0);

        for (int i = 0; i < NV; i++) begin
            do_reset();
            press_str(vecs[i].keys, lat);
            if (vecs[i].lat > 0) check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            check({vecs[i].name, "_status"}, int'(status), int'(vecs[i].st));
            check({vecs[i].name, "_err"}, int'(err_code), int'(vecs[i].err));
            check_display(vecs[i].name, vecs[i].val, vecs[i].val < 0);
        end

        // Chained operation on a previous result.
        do_reset();
        press_str("1234*5678=", lat);
        press_str("+1=", lat);
        check("chain_lat", lat, W+2);
        check_display("chain", 7006653, 1'b0);

        // cmd_valid held through boot and conversion: exactly one key taken.
        cmd = 4'd3;
        cmd_valid = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        n = 0;
        while (!cmd_ready && n < BOUND) begin
            @(posedge clock); #1;
            n++;
        end
        check("held_boot_latency", n, W);
        @(posedge clock); #1;
        check("held_accept_ready", int'(cmd_ready), 0);
        repeat (10) begin
            @(posedge clock); #1;
        end
        cmd_valid = 1'b0;
        wait_ready("held");
        check_display("held", 3, 1'b0);

        // Reset pulse in the middle of a multiply.
        do_reset();
        press_str("12*34", lat);
        cmd = 4'd14;
        cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
        end
        check("midmul_state", int'(state), 2);
        reset = 1'b1;
        #1;
        check("midmul_rst_state", int'(state), 0);
        check("midmul_rst_status", int'(status), 1);
        check("midmul_rst_ready", int'(cmd_ready), 0);
        check("midmul_rst_pos", int'(pos), 0);
        check("midmul_rst_data", int'(data), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        wait_ready("midmul_boot");
        check("midmul_err", int'(err_code), 0);
        check_display("midmul", 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
